// File: rtl/sd_spi_phy.sv
`default_nettype none
// ============================================================================
//  Module   : sd_spi_phy
//  Brief    : SPI mode-0 byte engine for the SD host. SD_CK is produced with a
//             clock enable from clk; two rates (INIT_DIV / FAST_DIV).
//             Build option SD_SPI_LOOPBACK_EN: sample SD_MOSI instead of the
//             synchronised SD_MISO.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_spi_phy #(
    parameter int DIV_W    = 8,
    parameter int INIT_DIV = 64,
    parameter int FAST_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fast_sel,
    input  logic       cs_assert,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    input  logic       SD_MISO,
    output logic       SD_CK,
    output logic       SD_MOSI,
    output logic       SD_CSn
);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_SHIFT    = 2'd1;
    localparam logic [1:0]       c_DONE     = 2'd2;
    localparam logic [DIV_W-1:0] c_INIT_DIV = DIV_W'(INIT_DIV);
    localparam logic [DIV_W-1:0] c_FAST_DIV = DIV_W'(FAST_DIV);
    localparam logic [DIV_W-1:0] c_ONE      = DIV_W'(1);

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_hcnt;
    logic [7:0]       r_tx_sh;
    logic [7:0]       r_rx_sh;
    logic             r_ck;
    logic             r_mosi;
    logic             r_csn;
    logic             r_tx_ready;
    logic             r_busy;
    logic             r_rx_valid;
    logic [7:0]       r_rx_data;
    logic             w_sample_bit;
    logic             w_tc;

`ifdef SD_SPI_LOOPBACK_EN
    assign w_sample_bit = r_mosi;
`else
    logic r_miso_s1;
    logic r_miso_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miso_s1 <= 1'b1;
            r_miso_s2 <= 1'b1;
        end else begin
            r_miso_s1 <= SD_MISO;
            r_miso_s2 <= r_miso_s1;
        end
    end

    assign w_sample_bit = r_miso_s2;
`endif

    assign w_tc = (r_div_cnt == (r_div - c_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_div      <= c_INIT_DIV;
            r_div_cnt  <= '0;
            r_hcnt     <= 4'd0;
            r_tx_sh    <= 8'hFF;
            r_rx_sh    <= 8'h00;
            r_ck       <= 1'b0;
            r_mosi     <= 1'b1;
            r_csn      <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_ck   <= 1'b0;
                    r_mosi <= 1'b1;
                    r_csn  <= ~cs_assert;
                    if (tx_valid) begin
                        r_div      <= fast_sel ? c_FAST_DIV : c_INIT_DIV;
                        r_mosi     <= tx_data[7];
                        r_tx_sh    <= {tx_data[6:0], 1'b1};
                        r_div_cnt  <= '0;
                        r_hcnt     <= 4'd0;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    if (w_tc) begin
                        r_div_cnt <= '0;
                        r_ck      <= ~r_ck;
                        r_hcnt    <= r_hcnt + 4'd1;
                        // Even half-period ends on a rising edge: sample.
                        // Odd ends on a falling edge: present next bit.
                        if (!r_hcnt[0]) begin
                            r_rx_sh <= {r_rx_sh[6:0], w_sample_bit};
                        end else if (r_hcnt == 4'd15) begin
                            r_mosi  <= 1'b1;
                            r_state <= c_DONE;
                        end else begin
                            r_mosi  <= r_tx_sh[7];
                            r_tx_sh <= {r_tx_sh[6:0], 1'b1};
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + c_ONE;
                    end
                end
                c_DONE: begin
                    r_rx_valid <= 1'b1;
                    r_rx_data  <= r_rx_sh;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= c_IDLE;
                end
                default: begin
                    r_ck       <= 1'b0;
                    r_mosi     <= 1'b1;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= c_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign SD_CK    = r_ck;
    assign SD_MOSI  = r_mosi;
    assign SD_CSn   = r_csn;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_phy.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_spi_phy
//  Brief    : Scoreboard bench for sd_spi_phy with a simple SD card model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_spi_phy;

    localparam int INIT_DIV = 4;
    localparam int FAST_DIV = 1;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       fast_sel  = 1'b0;
    logic       cs_assert = 1'b0;
    logic       tx_valid  = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       SD_MISO;
    logic       SD_CK;
    logic       SD_MOSI;
    logic       SD_CSn;

    sd_spi_phy #(.DIV_W(8), .INIT_DIV(INIT_DIV), .FAST_DIV(FAST_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .fast_sel(fast_sel), .cs_assert(cs_assert),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .SD_MISO(SD_MISO), .SD_CK(SD_CK), .SD_MOSI(SD_MOSI), .SD_CSn(SD_CSn)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Card: loads a byte when selected, shifts on SD_CK fall, releases MISO high.
    logic [7:0] card_next = 8'hFF;
    logic [7:0] card_byte = 8'hFF;
    logic [2:0] card_bit  = 3'd0;
    logic       ck_q      = 1'b0;
    logic       csn_q     = 1'b1;
    always @(SD_CK or SD_CSn) begin
        if (csn_q && !SD_CSn) begin
            card_byte = card_next;
            card_bit  = 3'd0;
        end else if (ck_q && !SD_CK && !SD_CSn) begin
            if (card_bit == 3'd7) card_byte = card_next;
            card_bit = card_bit + 3'd1;
        end
        ck_q  = SD_CK;
        csn_q = SD_CSn;
    end
    assign SD_MISO = SD_CSn ? 1'b1 : card_byte[~card_bit];

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        logic       csn;
        int         cyc;
    } exp_t;
    exp_t sbq[$];

    logic       prev_ck  = 1'b0;
    logic [7:0] mon_mosi = 8'h00;
    logic [7:0] mon_csn  = 8'h00;
    int         rises    = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ck = 1'b0;
        end else begin
            if (SD_CK && !prev_ck) begin
                rises++;
                mon_mosi = {mon_mosi[6:0], SD_MOSI};
                mon_csn  = {mon_csn[6:0], SD_CSn};
            end
            prev_ck = SD_CK;
            if (tx_ready) chk("idle_ck_mosi_busy", {SD_CK, SD_MOSI, busy}, 3'b010);
            if (rx_valid) begin
                if (sbq.size() == 0) begin
                    chk("rx_valid_unexpected", rx_valid, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    chk("rx_data", rx_data, e.rx);
                    chk("mosi_bits", mon_mosi, e.tx);
                    chk("csn_during_byte", mon_csn, {8{e.csn}});
                    chk("rx_valid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic send(input logic [7:0] tx, input logic [7:0] card,
                        input logic fast, input logic cs, output int acc);
        exp_t e;
        int   n;
        @(negedge clk);
        tx_data   = tx;
        fast_sel  = fast;
        cs_assert = cs;
        card_next = card;
        tx_valid  = 1'b1;
        n = 0;
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", tx_ready, 1'b1);
        acc   = cyc + 1;
        e.tx  = tx;
        e.csn = ~cs;
        e.cyc = acc + 16 * (fast ? FAST_DIV : INIT_DIV) + 1;
`ifdef SD_SPI_LOOPBACK_EN
        e.rx  = tx;
`else
        e.rx  = cs ? card : 8'hFF;
`endif
        sbq.push_back(e);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drain", sbq.size(), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int a1, a2, r0;

        // Reset with random inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tx_valid  = 1'($urandom);
            tx_data   = 8'($urandom);
            fast_sel  = 1'($urandom);
            cs_assert = 1'($urandom);
        end
        chk("reset_pins", {SD_CK, SD_MOSI, SD_CSn, tx_ready, busy, rx_valid}, 6'b011100);
        chk("reset_rx_data", rx_data, 8'h00);
        tx_valid = 1'b0; cs_assert = 1'b0; fast_sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Init rate, card returns A5.
        send(8'hFF, 8'hA5, 1'b0, 1'b1, a1);
        drain();

        // Fast rate, back-to-back, CS held low from idle.
        @(negedge clk); cs_assert = 1'b0; idle(3);
        card_next = 8'h00; cs_assert = 1'b1; idle(3);
        send(8'h40, 8'h00, 1'b1, 1'b1, a1);
        send(8'h00, 8'h00, 1'b1, 1'b1, a2);
        chk("back_to_back_gap", a2 - a1, 16 * FAST_DIV + 2);
        drain();

        // Dummy clocks with CS high.
        r0 = rises;
        for (int i = 0; i < 10; i++) send(8'hFF, 8'h00, 1'b0, 1'b0, a1);
        drain();
        chk("dummy_clock_count", rises - r0, 80);

        // Mid-byte changes of rate and select are ignored until next byte.
        send(8'hC3, 8'hFF, 1'b0, 1'b1, a1);
        idle(10);
        fast_sel = 1'b1; cs_assert = 1'b0;
        idle(10);
        fast_sel = 1'b0; cs_assert = 1'b1;
        idle(10);
        send(8'h81, 8'hFF, 1'b1, 1'b0, a1);
        drain();

        // Reset mid-byte while hcnt = 7.
        send(8'h55, 8'h12, 1'b0, 1'b1, a1);
        while (cyc < a1 + 7 * INIT_DIV + 1) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("abort_pins", {SD_CK, SD_MOSI, SD_CSn, tx_ready, busy, rx_valid}, 6'b011100);
        chk("abort_rx_data", rx_data, 8'h00);
        cs_assert = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(80);

        // Normal byte after abort (loopback build echoes tx).
        send(8'h3C, 8'h5A, 1'b0, 1'b1, a1);
        drain();
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
